instruction_fetch_unit: RTL

- Sits directly downstream of program_counter. Uses the PC address to read an opcode plus 0–2 operand bytes from program memory.
- Pulses the PC count strobe once per accepted byte.
- Presents the assembled instruction, with the ring_counter fetch mode it requires, to the decode/control stage over a valid/ready handshake.
- A flush input lets control abort an in-progress fetch on a PC jump load.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/instruction_fetch_unit_if.sv | 29 ++
 rtl/fetch_length_decode.sv | 20 ++
 rtl/instruction_fetch_unit.sv | 106 ++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding, ring_counter fetch modes and
// the position of the operand-length field inside an opcode.
package cpu_pkg;

  typedef enum logic [1:0] {
    F_OPCODE = 2'd0,
    F_LO     = 2'd1,
    F_HI     = 2'd2,
    HOLD     = 2'd3
  } fetch_state_t;

  localparam logic [1:0] MODE_SHORT = 2'b00;
  localparam logic [1:0] MODE_EXT1  = 2'b01;
  localparam logic [1:0] MODE_EXT2  = 2'b10;

  localparam int LEN_MSB = 7;
  localparam int LEN_LSB = 6;

  // Both 10 and 11 in the length field mean two operand bytes.
  function automatic logic [1:0] len_to_mode(input logic [1:0] len);
    return {len[1], len[0] & ~len[1]};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Program-memory read bus plus the instruction-register handshake towards decode.
interface instruction_fetch_unit_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic                    mem_read;
  logic [DATA_WIDTH-1:0]   mem_data;
  logic                    mem_valid;
  logic [DATA_WIDTH-1:0]   opcode;
  logic [2*DATA_WIDTH-1:0] operand;
  logic [1:0]              fetch_mode;
  logic                    ir_valid;
  logic                    ir_ready;

  modport master (
    output mem_addr, mem_read,
    input  mem_data, mem_valid,
    output opcode, operand, fetch_mode, ir_valid,
    input  ir_ready
  );

  modport slave (
    input  mem_addr, mem_read,
    output mem_data, mem_valid,
    input  opcode, operand, fetch_mode, ir_valid,
    output ir_ready
  );
endinterface

// File: rtl/fetch_length_decode.sv
// Maps an opcode length field to the ring_counter fetch mode and operand byte count.
module fetch_length_decode
  import cpu_pkg::*;
(
  input  logic [1:0] len_field,
  output logic [1:0] fetch_mode,
  output logic [1:0] operand_bytes
);

  always_comb begin
    fetch_mode    = len_to_mode(len_field);
    operand_bytes = 2'd0;
    case (fetch_mode)
      MODE_EXT1: operand_bytes = 2'd1;
      MODE_EXT2: operand_bytes = 2'd2;
      default:   operand_bytes = 2'd0;
    endcase
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetches opcode plus 0-2 operand bytes at the PC, strobes the PC per accepted
// byte and presents the assembled instruction to decode over valid/ready.
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  enable,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] pc_address,
  output logic                  pc_count,
  output logic                  fetch_error,
  instruction_fetch_unit_if.master bus
);

  localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(MEM_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  function automatic logic [TMO_W-1:0] sat_inc(input logic [TMO_W-1:0] v);
    return (v == TMO_MAX) ? v : v + 1'b1;
  endfunction

  fetch_state_t            state_q, state_d;
  logic                    mem_read;
  logic                    accept;
  logic                    tmo_inc;
  logic [1:0]              new_mode;
  logic [1:0]              new_bytes;
  logic [TMO_W-1:0]        tmo_cnt_q;
  logic [DATA_WIDTH-1:0]   opcode_q;
  logic [2*DATA_WIDTH-1:0] operand_q;
  logic [1:0]              mode_q;
  logic                    ir_valid_q;

  fetch_length_decode u_len (
    .len_field     (bus.mem_data[LEN_MSB:LEN_LSB]),
    .fetch_mode    (new_mode),
    .operand_bytes (new_bytes)
  );

  always_comb begin
    state_d  = state_q;
    mem_read = 1'b0;
    case (state_q)
      F_OPCODE:   mem_read = enable;
      F_LO, F_HI: mem_read = 1'b1;
      default:    mem_read = 1'b0;
    endcase
    accept  = mem_read & bus.mem_valid & ~flush;
    tmo_inc = mem_read & ~bus.mem_valid & ~flush;
    case (state_q)
      F_OPCODE: if (accept) state_d = (new_bytes != 2'd0) ? F_LO : HOLD;
      F_LO:     if (accept) state_d = (mode_q == MODE_EXT2) ? F_HI : HOLD;
      F_HI:     if (accept) state_d = HOLD;
      HOLD:     if (ir_valid_q && bus.ir_ready) state_d = F_OPCODE;
      default:  state_d = F_OPCODE;
    endcase
    // A flush accompanies a PC jump load, so whatever was half-fetched is stale.
    if (flush) state_d = F_OPCODE;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q     <= F_OPCODE;
      opcode_q    <= '0;
      operand_q   <= '0;
      mode_q      <= MODE_SHORT;
      ir_valid_q  <= 1'b0;
      fetch_error <= 1'b0;
      tmo_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      ir_valid_q <= (state_d == HOLD);
      if (accept) begin
        case (state_q)
          F_OPCODE: begin
            opcode_q  <= bus.mem_data;
            operand_q <= '0;
            mode_q    <= new_mode;
          end
          F_LO:    operand_q[DATA_WIDTH-1:0] <= bus.mem_data;
          F_HI:    operand_q[2*DATA_WIDTH-1:DATA_WIDTH] <= bus.mem_data;
          default: ;
        endcase
      end
      if (flush || accept) tmo_cnt_q <= '0;
      else if (tmo_inc)    tmo_cnt_q <= sat_inc(tmo_cnt_q);
      // Sticky: the FSM keeps waiting, control decides what to do about it.
      if (tmo_inc && (tmo_cnt_q >= TMO_LAST)) fetch_error <= 1'b1;
    end
  end

  assign pc_count       = accept;
  assign bus.mem_read   = mem_read;
  assign bus.mem_addr   = pc_address;
  assign bus.opcode     = opcode_q;
  assign bus.operand    = operand_q;
  assign bus.fetch_mode = mode_q;
  assign bus.ir_valid   = ir_valid_q;

endmodule
